// File: rtl/core_mc.sv
// Multi-cycle 8-register accumulator-style core: FETCH/EXEC/MEM/HALT sequencing
// over separate instruction and data memory request/ack ports.
module core_mc #(
  parameter int unsigned D         = 12,
  parameter int unsigned W         = 8,
  parameter int unsigned HALT_ADDR = 128
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [D-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [8:0]   imem_data,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [W-1:0] dmem_addr,
  output logic [W-1:0] dmem_wdata,
  input  logic         dmem_ack,
  input  logic [W-1:0] dmem_rdata,
  output logic         done
);

  localparam int unsigned NREG = 8;
  localparam int unsigned IW   = 9;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t         state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic [IW-1:0]  ir_q, ir_d;
  logic [W-1:0]   regs_q [NREG];
  logic [W-1:0]   regs_d [NREG];
  logic           z_q, z_d, p_q, p_d, c_q, c_d;

  logic [2:0]     op;
  logic [2:0]     rb_idx, ra_idx;
  logic [W-1:0]   rb_val, ra_val;
  logic [W:0]     sum, diff;
  logic [W-1:0]   res;
  logic           carry;
  logic [D-1:0]   pc_inc, pc_br, pc_next;

  assign op     = ir_q[8:6];
  assign rb_idx = ir_q[5:3];
  assign ra_idx = ir_q[2:0];
  assign rb_val = regs_q[rb_idx];
  assign ra_val = regs_q[ra_idx];
  assign sum    = {1'b0, rb_val} + {1'b0, ra_val};
  assign diff   = {1'b0, rb_val} - {1'b0, ra_val};
  assign pc_inc = pc_q + D'(1);
  // 6-bit {rB,rA} offset sign-extended to PC width; wraps modulo 2^D
  assign pc_br  = pc_q + {{(D-6){ir_q[5]}}, ir_q[5:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
      p_q     <= 1'b0;
      c_q     <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      p_q     <= p_d;
      c_q     <= c_d;
      regs_q  <= regs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    z_d     = z_q;
    p_d     = p_q;
    c_d     = c_q;
    regs_d  = regs_q;
    res     = '0;
    carry   = 1'b0;
    pc_next = pc_inc;
    unique case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op == 3'b101 || op == 3'b110) begin
          state_d = S_MEM;
        end else begin
          if (op == 3'b111) begin
            pc_next = z_q ? pc_br : pc_inc;
          end else begin
            unique case (op)
              3'b000:  begin res = sum[W-1:0];  carry = sum[W];  end
              3'b001:  begin res = diff[W-1:0]; carry = diff[W]; end
              3'b010:  res = rb_val & ra_val;
              3'b011:  res = rb_val ^ ra_val;
              default: begin res = {rb_val[W-2:0], c_q}; carry = rb_val[W-1]; end
            endcase
            regs_d[rb_idx] = res;
            z_d = (res == '0);
            p_d = ^res;
            c_d = carry;
          end
          pc_d    = pc_next;
          state_d = (pc_next == D'(HALT_ADDR)) ? S_HALT : S_FETCH;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (op == 3'b101) regs_d[rb_idx] = dmem_rdata;
          pc_d    = pc_inc;
          state_d = (pc_inc == D'(HALT_ADDR)) ? S_HALT : S_FETCH;
        end
      end
      default: ;
    endcase
  end

  // Request strobes decode straight from state so reset drops them at once
  assign imem_req   = (state_q == S_FETCH) && !reset;
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = (op == 3'b110);
  assign dmem_addr  = ra_val;
  assign dmem_wdata = rb_val;
  assign done       = (state_q == S_HALT);

endmodule
